// File: rtl/lbist_pkg.sv
// Shared types and step functions for the logic-BIST controller.
// Functions work on 32-bit containers; callers zero-extend narrower values
// and truncate the result, so PAT_W and DATA_W must not exceed 32.
package lbist_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SEED,
    S_RUN,
    S_DRAIN,
    S_COMPARE,
    S_DONE
  } state_t;

  localparam int CNT_W = 16;

  // Fibonacci LFSR step: shift left, feed back the parity of the tapped stages.
  // The upper bits of value must be zero so taps beyond the width drop out.
  function automatic logic [31:0] lfsr_next(input logic [31:0] value,
                                            input logic [31:0] taps);
    return {value[30:0], ^(value & taps)};
  endfunction

  // Galois MISR step. msb is the top bit of the real-width signature, passed
  // separately because the container is wider than the register.
  function automatic logic [31:0] misr_next(input logic [31:0] sig,
                                            input logic [31:0] poly,
                                            input logic [31:0] resp,
                                            input logic        msb);
    return (sig << 1) ^ (msb ? poly : 32'h0) ^ resp;
  endfunction

endpackage

// File: rtl/lbist_misr.sv
// One response-compaction MISR channel.
// Ports: clk/rst (sync, active-high), clr zeroes the signature, en folds
// resp into the signature for one cycle, sig is the live register.
module lbist_misr
  import lbist_pkg::*;
#(
  parameter int                DATA_W    = 32,
  parameter logic [DATA_W-1:0] MISR_POLY = 32'h04C11DB7
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              en,
  input  logic [DATA_W-1:0] resp,
  output logic [DATA_W-1:0] sig
);

  always_ff @(posedge clk) begin
    if (rst) begin
      sig <= '0;
    end else if (clr) begin
      sig <= '0;
    end else if (en) begin
      sig <= DATA_W'(misr_next(32'(sig), 32'(MISR_POLY), 32'(resp), sig[DATA_W-1]));
    end
  end

endmodule

// File: rtl/lbist_multichannel_ctrl.sv
// Logic-BIST controller: one LFSR drives a shared stimulus bus, N_CH MISRs
// compact the channel responses after RESP_LAT cycles, and the signatures
// are compared against GOLDEN to give pass_o / fail_mask_o.
// Ports: start/abort control a run; test_mode_o/pattern_o drive the CUTs;
// resp_i returns the flattened responses; busy_o/done_o/pass_o/fail_mask_o/
// aborted_o report status; signature_o/pattern_cnt_o are debug views.
module lbist_multichannel_ctrl
  import lbist_pkg::*;
#(
  parameter int                       PAT_W     = 32,
  parameter logic [PAT_W-1:0]         LFSR_TAPS = 32'h80200003,
  parameter logic [PAT_W-1:0]         SEED      = 32'h0000_ACE1,
  parameter int                       DATA_W    = 32,
  parameter int                       N_CH      = 2,
  parameter logic [DATA_W-1:0]        MISR_POLY = 32'h04C11DB7,
  parameter int                       PATTERNS  = 256,
  parameter int                       RESP_LAT  = 1,
  parameter logic [N_CH*DATA_W-1:0]   GOLDEN    = '0
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic                   abort,
  output logic                   test_mode_o,
  output logic [PAT_W-1:0]       pattern_o,
  input  logic [N_CH*DATA_W-1:0] resp_i,
  output logic                   busy_o,
  output logic                   done_o,
  output logic                   pass_o,
  output logic [N_CH-1:0]        fail_mask_o,
  output logic                   aborted_o,
  output logic [N_CH*DATA_W-1:0] signature_o,
  output logic [CNT_W-1:0]       pattern_cnt_o
);

  // An all-zero seed would lock the LFSR up.
  localparam logic [PAT_W-1:0] SEED_EFF   = (SEED == '0) ? PAT_W'(1) : SEED;
  localparam logic [2:0]       DRAIN_LAST = 3'((RESP_LAT == 0) ? 0 : RESP_LAT - 1);
  localparam logic [CNT_W-1:0] RUN_LAST   = CNT_W'(PATTERNS - 1);
  localparam logic [CNT_W-1:0] CNT_MAX    = CNT_W'(PATTERNS);

  state_t           state_q, state_d;
  logic [PAT_W-1:0] lfsr_q;
  logic [CNT_W-1:0] cnt_q;
  logic [2:0]       drain_q;
  logic             is_run;
  logic             abort_run;
  logic             cap_raw;
  logic             cap_en;
  logic [N_CH-1:0]  mismatch;

  // Abort only matters once a run has left IDLE.
  assign abort_run = abort && (state_q != S_IDLE);

  // ---------------- FSM ----------------
  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d     = state_q;
    is_run      = 1'b0;
    test_mode_o = 1'b0;
    busy_o      = 1'b1;
    done_o      = 1'b0;
    case (state_q)
      S_IDLE: begin
        busy_o = 1'b0;
        if (start && !abort) state_d = S_SEED;
      end
      S_SEED: begin
        test_mode_o = 1'b1;
        state_d     = S_RUN;
      end
      S_RUN: begin
        test_mode_o = 1'b1;
        is_run      = 1'b1;
        if (cnt_q == RUN_LAST) state_d = (RESP_LAT == 0) ? S_COMPARE : S_DRAIN;
      end
      S_DRAIN: begin
        test_mode_o = 1'b1;
        if (drain_q == DRAIN_LAST) state_d = S_COMPARE;
      end
      S_COMPARE: state_d = S_DONE;
      S_DONE: begin
        done_o  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    if (abort_run) state_d = S_IDLE;
  end

  // ---------------- capture-valid delay line ----------------
  // The valid bit follows RUN by RESP_LAT cycles. Captures are confined to
  // RUN/DRAIN so an aborted run leaves the MISRs untouched afterwards.
  generate
    if (RESP_LAT == 0) begin : g_nolat
      assign cap_raw = is_run;
    end else begin : g_lat
      logic [RESP_LAT-1:0] vld_pipe;
      always_ff @(posedge clk) begin
        if (rst || abort_run || (state_q == S_SEED)) vld_pipe <= '0;
        else vld_pipe <= (vld_pipe << 1) | RESP_LAT'(is_run);
      end
      assign cap_raw = vld_pipe[RESP_LAT-1];
    end
  endgenerate

  assign cap_en = cap_raw && ((state_q == S_RUN) || (state_q == S_DRAIN)) && !abort;

  // ---------------- LFSR, counters, result flags ----------------
  always_ff @(posedge clk) begin
    if (rst) begin
      lfsr_q      <= SEED_EFF;
      cnt_q       <= '0;
      drain_q     <= '0;
      pass_o      <= 1'b0;
      fail_mask_o <= '0;
      aborted_o   <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start && !abort) begin
            pass_o      <= 1'b0;
            fail_mask_o <= '0;
            aborted_o   <= 1'b0;
          end
        end
        S_SEED: begin
          lfsr_q <= SEED_EFF;
          cnt_q  <= '0;
        end
        S_RUN: begin
          lfsr_q  <= PAT_W'(lfsr_next(32'(lfsr_q), 32'(LFSR_TAPS)));
          drain_q <= '0;
          if (cnt_q != CNT_MAX) cnt_q <= cnt_q + 1'b1;
        end
        S_DRAIN: drain_q <= drain_q + 1'b1;
        S_COMPARE: begin
          fail_mask_o <= mismatch;
          pass_o      <= (mismatch == '0);
        end
        default: ;
      endcase
      if (abort_run) begin
        aborted_o   <= 1'b1;
        pass_o      <= 1'b0;
        fail_mask_o <= '1;
      end
    end
  end

  assign pattern_o     = is_run ? lfsr_q : '0;
  assign pattern_cnt_o = cnt_q;

  // ---------------- per-channel MISRs ----------------
  generate
    for (genvar c = 0; c < N_CH; c++) begin : g_ch
      lbist_misr #(
        .DATA_W    (DATA_W),
        .MISR_POLY (MISR_POLY)
      ) u_misr (
        .clk  (clk),
        .rst  (rst),
        .clr  (state_q == S_SEED),
        .en   (cap_en),
        .resp (resp_i[c*DATA_W +: DATA_W]),
        .sig  (signature_o[c*DATA_W +: DATA_W])
      );
      assign mismatch[c] = signature_o[c*DATA_W +: DATA_W] != GOLDEN[c*DATA_W +: DATA_W];
    end
  endgenerate

endmodule

// File: tb/tb_lbist_multichannel_ctrl.sv
// Bench for lbist_multichannel_ctrl: one instance with no response latency
// and zero goldens, one with latency 3 and channel-0 golden 8'h08.
module tb_lbist_multichannel_ctrl;

  localparam int         P     = 4;
  localparam logic [7:0] TAPS  = 8'hB8;
  localparam logic [7:0] SEED8 = 8'hE1;
  localparam logic [7:0] POLY  = 8'h1D;

  logic        clk = 1'b0;
  logic        rst;
  logic        sel;
  logic        start_v, abort_v;
  logic [15:0] resp_v;

  logic        tm0, busy0, done0, pass0, ab0, tm3, busy3, done3, pass3, ab3;
  logic [7:0]  pat0, pat3;
  logic [1:0]  mask0, mask3;
  logic [15:0] sig0, sig3, cnt0, cnt3;

  logic        t_tm, t_busy, t_done, t_pass, t_ab;
  logic [7:0]  t_pat;
  logic [1:0]  t_mask;
  logic [15:0] t_sig, t_cnt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  lbist_multichannel_ctrl #(
    .PAT_W(8), .LFSR_TAPS(TAPS), .SEED(SEED8), .DATA_W(8), .N_CH(2),
    .MISR_POLY(POLY), .PATTERNS(P), .RESP_LAT(0), .GOLDEN(16'h0000)
  ) u_dut0 (
    .clk(clk), .rst(rst), .start(start_v & ~sel), .abort(abort_v & ~sel),
    .test_mode_o(tm0), .pattern_o(pat0), .resp_i(resp_v), .busy_o(busy0),
    .done_o(done0), .pass_o(pass0), .fail_mask_o(mask0), .aborted_o(ab0),
    .signature_o(sig0), .pattern_cnt_o(cnt0)
  );

  lbist_multichannel_ctrl #(
    .PAT_W(8), .LFSR_TAPS(TAPS), .SEED(SEED8), .DATA_W(8), .N_CH(2),
    .MISR_POLY(POLY), .PATTERNS(P), .RESP_LAT(3), .GOLDEN(16'h0008)
  ) u_dut3 (
    .clk(clk), .rst(rst), .start(start_v & sel), .abort(abort_v & sel),
    .test_mode_o(tm3), .pattern_o(pat3), .resp_i(resp_v), .busy_o(busy3),
    .done_o(done3), .pass_o(pass3), .fail_mask_o(mask3), .aborted_o(ab3),
    .signature_o(sig3), .pattern_cnt_o(cnt3)
  );

  always_comb begin
    t_tm   = sel ? tm3   : tm0;
    t_busy = sel ? busy3 : busy0;
    t_done = sel ? done3 : done0;
    t_pass = sel ? pass3 : pass0;
    t_ab   = sel ? ab3   : ab0;
    t_pat  = sel ? pat3  : pat0;
    t_mask = sel ? mask3 : mask0;
    t_sig  = sel ? sig3  : sig0;
    t_cnt  = sel ? cnt3  : cnt0;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  // Reference LFSR: new bit = parity of tapped stages, shifted in at the bottom.
  function automatic logic [7:0] lfsr_ref(input logic [7:0] v);
    int par = $countones(v & TAPS) % 2;
    return 8'(((int'(v) * 2) % 256) + par);
  endfunction

  // Reference MISR over the four captured bytes of caps (byte j = capture j).
  function automatic logic [7:0] misr_ref(input logic [31:0] caps);
    int s = 0;
    for (int j = 0; j < P; j++) begin
      int hi = (s >= 128);
      s = (s * 2) % 256;
      if (hi != 0) s = s ^ int'(POLY);
      s = s ^ int'(caps[j*8 +: 8]);
    end
    return 8'(s);
  endfunction

  task automatic check_all_zero(input string nm);
    chk({nm, " flags"}, 32'({t_busy, t_tm, t_done, t_pass, t_mask, t_ab}), 32'h0);
    chk({nm, " sig"}, 32'(t_sig), 32'h0);
    chk({nm, " pattern"}, 32'(t_pat), 32'h0);
    chk({nm, " cnt"}, 32'(t_cnt), 32'h0);
  endtask

  // One full run; resp bytes are presented exactly on capture cycles and
  // random noise elsewhere, so a mistimed capture corrupts the signature.
  task automatic do_run(input string nm, input bit s, input logic [31:0] r0,
                        input logic [31:0] r1, input logic [15:0] esig,
                        input logic epass, input logic [1:0] emask,
                        input bit extra_start);
    int lat = s ? 3 : 0;
    int dpos = P + lat + 2;
    int j;
    logic [7:0] lf = SEED8;
    sel = s;
    @(negedge clk);
    start_v = 1'b1;
    resp_v  = 16'($urandom);
    @(negedge clk);
    start_v = 1'b0;
    for (int i = 0; i <= dpos + 10; i++) begin
      chk($sformatf("%s test_mode c%0d", nm, i), 32'(t_tm), 32'(i <= P + lat));
      chk($sformatf("%s done c%0d", nm, i), 32'(t_done), 32'(i == dpos));
      chk($sformatf("%s busy c%0d", nm, i), 32'(t_busy), 32'(i <= dpos));
      if (i >= 1 && i <= P) begin
        chk($sformatf("%s pattern c%0d", nm, i), 32'(t_pat), 32'(lf));
        chk($sformatf("%s cnt c%0d", nm, i), 32'(t_cnt), 32'(i - 1));
        lf = lfsr_ref(lf);
      end
      j = i - 1 - lat;
      if (j >= 0 && j < P) resp_v = {r1[j*8 +: 8], r0[j*8 +: 8]};
      else                 resp_v = 16'($urandom);
      start_v = extra_start && (i == 2);
      @(negedge clk);
    end
    chk({nm, " signature"}, 32'(t_sig), 32'(esig));
    chk({nm, " pass"}, 32'(t_pass), 32'(epass));
    chk({nm, " fail_mask"}, 32'(t_mask), 32'(emask));
    chk({nm, " aborted"}, 32'(t_ab), 32'h0);
    chk({nm, " cnt_sat"}, 32'(t_cnt), 32'(P));
  endtask

  typedef struct packed {
    logic        sel;
    logic [31:0] r0;
    logic [31:0] r1;
    logic [15:0] sig;
    logic        pass;
    logic [1:0]  mask;
  } vec_t;

  vec_t tbl[7];

  initial begin
    logic [31:0] r0, r1;
    logic [7:0]  s0, s1;
    logic [1:0]  m;
    bit          s;

    tbl[0] = '{1'b0, 32'h0000_0000, 32'h0000_0000, 16'h0000, 1'b1, 2'b00};
    tbl[1] = '{1'b0, 32'h0000_0001, 32'h0000_0000, 16'h0008, 1'b0, 2'b01};
    tbl[2] = '{1'b0, 32'h0000_0080, 32'h0000_0000, 16'h0074, 1'b0, 2'b01};
    tbl[3] = '{1'b0, 32'h0000_0000, 32'h0100_0000, 16'h0100, 1'b0, 2'b10};
    tbl[4] = '{1'b0, 32'h0001_0000, 32'h0000_0080, 16'h7402, 1'b0, 2'b11};
    tbl[5] = '{1'b1, 32'h0000_0001, 32'h0000_0000, 16'h0008, 1'b1, 2'b00};
    tbl[6] = '{1'b1, 32'h0000_0000, 32'h0000_0000, 16'h0000, 1'b0, 2'b01};

    rst = 1'b1; sel = 1'b0; start_v = 1'b0; abort_v = 1'b0; resp_v = '0;
    repeat (2) @(negedge clk);
    check_all_zero("reset lat0");
    sel = 1'b1;
    check_all_zero("reset lat3");
    rst = 1'b0;

    for (int k = 0; k < 7; k++)
      do_run($sformatf("tbl%0d", k), tbl[k].sel, tbl[k].r0, tbl[k].r1,
             tbl[k].sig, tbl[k].pass, tbl[k].mask, 1'b0);

    // Abort during the second RUN cycle.
    sel = 1'b0;
    @(negedge clk); start_v = 1'b1; resp_v = '0;
    @(negedge clk); start_v = 1'b0;
    @(negedge clk);
    @(negedge clk); abort_v = 1'b1;
    @(negedge clk); abort_v = 1'b0;
    chk("abort busy", 32'(t_busy), 32'h0);
    chk("abort test_mode", 32'(t_tm), 32'h0);
    chk("abort aborted", 32'(t_ab), 32'h1);
    chk("abort pass", 32'(t_pass), 32'h0);
    chk("abort mask", 32'(t_mask), 32'h3);
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("abort no_done %0d", i), 32'(t_done), 32'h0);
      @(negedge clk);
    end
    // abort and start together in IDLE: nothing starts, aborted stays set.
    start_v = 1'b1; abort_v = 1'b1;
    @(negedge clk); start_v = 1'b0; abort_v = 1'b0;
    chk("abort+start busy", 32'(t_busy), 32'h0);
    chk("abort+start aborted", 32'(t_ab), 32'h1);
    @(negedge clk);
    chk("abort+start busy2", 32'(t_busy), 32'h0);
    do_run("post_abort", 1'b0, 32'h0, 32'h0, 16'h0000, 1'b1, 2'b00, 1'b0);

    // start while busy is ignored: exactly one done in the window.
    do_run("start_busy", 1'b0, 32'h0000_0001, 32'h0, 16'h0008, 1'b0, 2'b01, 1'b1);

    // rst during the third RUN cycle.
    sel = 1'b0;
    @(negedge clk); start_v = 1'b1;
    @(negedge clk); start_v = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check_all_zero("mid_rst");
    rst = 1'b0;
    @(negedge clk);
    do_run("post_rst", 1'b0, 32'h0, 32'h0, 16'h0000, 1'b1, 2'b00, 1'b0);

    // Random responses checked against the reference model.
    for (int k = 0; k < 16; k++) begin
      s  = 1'($urandom);
      r0 = (k % 5 == 0) ? 32'h0 : $urandom;
      r1 = (k % 7 == 0) ? 32'h0 : $urandom;
      s0 = misr_ref(r0);
      s1 = misr_ref(r1);
      m  = {s1 != 8'h00, s0 != (s ? 8'h08 : 8'h00)};
      do_run($sformatf("rnd%0d", k), s, r0, r1, {s1, s0}, m == 2'b00, m, 1'b0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/lbist_multichannel_ctrl.md
Name: lbist_multichannel_ctrl

Overview:
Parametrised logic-BIST controller, successor to the fixed single-ALU LFSR/MISR BIST inside the execute stage. A single LFSR drives a shared stimulus bus into N_CH units under test (primary ALU, shadow ALU, writeback muxes). Each channel's response is compacted in its own MISR, with a programmable response latency. Results are compared against per-channel golden signatures, and a pass flag plus a per-channel fail mask are reported to the hardware-fault logic in Pipeline_top.

Parameters:
PAT_W, 32, stimulus (LFSR) width
LFSR_TAPS, 32'h80200003, Fibonacci tap mask; bit i set = stage i feeds XOR
SEED, 32'h0000_ACE1, LFSR load value; 0 is illegal and is replaced by 1
DATA_W, 32, response/MISR width per channel
N_CH, 2, number of response channels (1..8)
MISR_POLY, 32'h04C11DB7, Galois MISR feedback polynomial
PATTERNS, 256, patterns applied per run (1..65535)
RESP_LAT, 1, cycles from pattern_o to matching resp_i (0..7)
GOLDEN, {N_CH{32'h0}}, flattened golden signatures; channel c = bits [c*DATA_W +: DATA_W]

Ports:
clk  in  1  clock
rst  in  1  synchronous, active-high reset
start  in  1  begin run; sampled in IDLE only
abort  in  1  terminate run immediately
test_mode_o  out  1  high in SEED/RUN/DRAIN; steers the CUT input muxes
pattern_o  out  PAT_W  current LFSR stimulus
resp_i  in  N_CH*DATA_W  channel responses, flattened
busy_o  out  1  high in any state other than IDLE
done_o  out  1  one-cycle pulse when a run completes normally
pass_o  out  1  all channels matched; held until the next start/abort/rst
fail_mask_o  out  N_CH  bit c = channel c mismatched; held like pass_o
aborted_o  out  1  last run was aborted; held
signature_o  out  N_CH*DATA_W  live MISR contents
pattern_cnt_o  out  16  patterns issued in the current run

Behaviour:
- Reset values: all outputs 0; state IDLE; LFSR = SEED (or 1 if SEED==0); MISRs = 0.
- FSM: IDLE -> SEED -> RUN -> DRAIN -> COMPARE -> DONE -> IDLE.
- IDLE + start: go to SEED. In SEED, load the LFSR, clear the MISRs, pattern_cnt = 0, and clear pass/fail_mask/aborted.
- SEED: lasts 1 cycle.
- RUN: lasts exactly PATTERNS cycles. pattern_o = LFSR value; the LFSR steps each RUN cycle; pattern_cnt_o increments. The first RUN cycle presents SEED.
- Fibonacci step: lfsr <= {lfsr[PAT_W-2:0], ^(lfsr & LFSR_TAPS)}.
- Capture: a valid bit is delayed RESP_LAT cycles behind RUN. When the delayed bit is high, every MISR updates as sig <= (sig<<1) ^ (sig[DATA_W-1] ? MISR_POLY : 0) ^ resp_c.
- Capture count: exactly PATTERNS captures per run.
- DRAIN: lasts RESP_LAT cycles and is skipped when RESP_LAT = 0.
- COMPARE: 1 cycle. fail_mask[c] <= (sig_c != GOLDEN_c); pass <= (mismatch mask == 0).
- DONE: done_o = 1 for one cycle, then return to IDLE.
- done_o rises PATTERNS+RESP_LAT+2 clock edges after the edge that sampled start.
- start while busy: ignored.
- abort in any non-IDLE state: return to IDLE next edge. test_mode_o drops, aborted_o=1, pass_o=0, fail_mask_o=all ones, no done_o. MISRs keep their contents for debug.
- abort and start in the same cycle in IDLE: abort wins; no run starts and aborted_o is left unchanged.
- rst mid-run: all state returns to reset values; no done_o.
- pattern_cnt_o saturates at PATTERNS.
- signature_o is frozen outside SEED/capture cycles.

Decomposition:
- Package lbist_pkg: state enum (IDLE, SEED, RUN, DRAIN, COMPARE, DONE), CNT_W=16, a function lfsr_next(value, taps), a function misr_next(sig, poly, resp).
- Sub-module lbist_misr, parametrised on DATA_W and MISR_POLY, with ports clk, rst, clr, en, resp, sig. The controller instantiates N_CH copies in a generate loop.
- The LFSR and FSM stay in the top module.

Test Plan (configuration: DATA_W=8, PAT_W=8, N_CH=2, PATTERNS=4, RESP_LAT=0, MISR_POLY=8'h1D, GOLDEN=0 unless stated):
- Zero-response run: resp_i=0 -> done_o pulses 6 edges after start; signature_o=16'h0000; pass_o=1; fail_mask_o=2'b00; first RUN pattern_o=SEED.
- Single-bit fault on channel 0: resp0=8'h01 on the first capture only, resp1=0 -> sig0=8'h08, sig1=8'h00; pass_o=0; fail_mask_o=2'b01.
- Latency: RESP_LAT=3, same stimulus as the fault test but delayed 3 cycles -> sig0=8'h08; done_o at edge 9; test_mode_o high for 8 cycles.
- Abort: abort at the 2nd RUN cycle -> IDLE next edge; aborted_o=1; pass_o=0; fail_mask_o=2'b11; no done_o. A following start runs clean with pass_o=1 and aborted_o=0.
- start while busy, and rst at the 3rd RUN cycle -> extra start ignored (exactly one done_o); after rst all outputs=0 and the LFSR reloads SEED.
- MISR wrap: resp0=8'h80 on the first capture only -> sig0 = 8'h1D shifted twice = 8'h74 (shifts: 0x80 -> 0x1D -> 0x3A -> 0x74), with no X propagation.
